c432_key_loader: RTL and testbench

//  Upstream key-provisioning stage for the locked c432 core. Shifts a 24-bit key in

---
 rtl/c432_key_loader.sv | 120 ++++++++++++
 tb/tb_c432_key_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: shifts a 24-bit key (plus optional
// checksum) LSB first and freezes it on key_p/key_x. Option macro: C432_KEYLD_CHECKSUM_EN.
module c432_key_loader #(
  parameter int KEY_W     = 24,
  parameter int CHK_W     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        sdi,
  input  logic        sdi_valid,
  output logic        sdi_ready,
  output logic [3:0]  key_p,
  output logic [19:0] key_x,
  output logic        key_locked,
  output logic        key_error,
  output logic        busy
);

`ifdef C432_KEYLD_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  localparam int FRAME_W = CHECKSUM_EN ? KEY_W + CHK_W : KEY_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_LOCKED,
    ST_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [3:0]         retry_q, retry_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               chk_pass;

`ifdef C432_KEYLD_CHECKSUM_EN
  // Checksum is the XOR fold of the three key bytes.
  assign chk_pass = (shadow_q[KEY_W +: CHK_W] ==
                     (shadow_q[7:0] ^ shadow_q[15:8] ^ shadow_q[23:16]));
`else
  assign chk_pass = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    retry_d   = retry_q;
    key_d     = key_q;

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shadow_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (sdi_valid) begin
          shadow_d[bit_cnt_q] = sdi;
          bit_cnt_d           = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_IDX) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_pass) begin
          state_d = ST_LOCKED;
          key_d   = shadow_q[KEY_W-1:0];
        end else begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == 4'(MAX_RETRY)) ? ST_ERROR : ST_IDLE;
        end
      end
      default: ; // LOCKED and ERROR are terminal until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the shadow register is
  // reset too so an aborted load can never leave partial key bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      retry_q   <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      retry_q   <= retry_d;
      key_q     <= key_d;
    end
  end

  // key_q is only ever loaded on entry to LOCKED, so it is zero in every other state.
  assign key_p      = key_q[3:0];
  assign key_x      = key_q[23:4];
  assign sdi_ready  = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign key_locked = (state_q == ST_LOCKED);
`ifdef C432_KEYLD_CHECKSUM_EN
  assign key_error  = (state_q == ST_ERROR);
`else
  assign key_error  = 1'b0;
`endif

endmodule

// File: tb/tb_c432_key_loader.sv
// Scoreboard bench for c432_key_loader: stimulus pushes expected load outcomes,
// a monitor pops them whenever a load attempt finishes (busy falls).
module tb_c432_key_loader;

`ifdef C432_KEYLD_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif
  localparam int FRAME     = CHK_ON ? 32 : 24;
  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        sdi = 1'b0;
  logic        sdi_valid = 1'b0;
  logic        sdi_ready;
  logic [3:0]  key_p;
  logic [19:0] key_x;
  logic        key_locked;
  logic        key_error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int          t0;
    int          lat;
    bit          locked;
    bit          error;
    logic [23:0] key;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   busy_prev = 1'b0;
  int   m_retries = 0;

  c432_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .key_p      (key_p),
    .key_x      (key_x),
    .key_locked (key_locked),
    .key_error  (key_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a load attempt ends when busy drops outside of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got load completion expected none");
        end else begin
          mon_e = exp_q.pop_front();
          check("latency", 32'(edge_cnt - mon_e.t0), 32'(mon_e.lat));
          check("key_locked", {31'd0, key_locked}, {31'd0, mon_e.locked});
          check("key_error", {31'd0, key_error}, {31'd0, mon_e.error});
          check("key_p", {28'd0, key_p}, {28'd0, mon_e.key[3:0]});
          check("key_x", {12'd0, key_x}, {12'd0, mon_e.key[23:4]});
        end
      end
      busy_prev = busy;
    end
  end

  function automatic logic [7:0] fold(input logic [23:0] k);
    logic [7:0] f = 8'h00;
    for (int i = 0; i < 3; i++) f ^= k[8*i +: 8];
    return f;
  endfunction

  // gap_mode: 0 back-to-back, 1 idle cycle before every bit, 2 random idle cycles.
  task automatic do_load(input logic [23:0] key, input logic [7:0] chk,
                         input int gap_mode, output int outcome);
    exp_t        e;
    logic [31:0] frame;
    int          gaps[32];
    int          total;
    bit          pass;
    frame = {chk, key};
    pass  = CHK_ON ? (chk == fold(key)) : 1'b1;
    total = 0;
    for (int i = 0; i < FRAME; i++) begin
      gaps[i] = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      total  += gaps[i];
    end
    e.lat = FRAME + total + 2;
    if (pass) begin
      e.locked = 1'b1; e.error = 1'b0; e.key = key; outcome = 1;
    end else begin
      m_retries++;
      e.locked = 1'b0; e.error = (m_retries == MAX_RETRY); e.key = '0;
      outcome  = e.error ? 2 : 0;
    end
    load_req = 1'b1;
    e.t0     = edge_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      repeat (gaps[i]) begin
        sdi_valid = 1'b0;
        sdi       = 1'($urandom);
        @(negedge clk);
      end
      sdi_valid = 1'b1;
      sdi       = frame[i];
      @(negedge clk);
    end
    sdi_valid = 1'b0;
    sdi       = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, sdi_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_locked"}, {31'd0, key_locked}, 32'd0);
    check({tag, "_error"}, {31'd0, key_error}, 32'd0);
    check({tag, "_keys"}, {8'd0, key_x, key_p}, 32'd0);
  endtask

  // Called on a negedge; asserts reset mid-cycle and checks outputs clear at once.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    load_req  = 1'b0;
    sdi_valid = 1'b0;
    #1 check_all_zero(tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_retries = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic partial_load(input int nbits);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdi_valid = 1'b1;
      sdi       = 1'($urandom);
      @(negedge clk);
    end
    sdi_valid = 1'b0;
    check("partial_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic locked_immunity(input logic [23:0] key);
    bit rdy_seen = 1'b0;
    bit busy_seen = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sdi_valid = 1'b1;
      sdi       = 1'($urandom);
      @(negedge clk);
      if (sdi_ready) rdy_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    sdi_valid = 1'b0;
    check("lk_ready_seen", {31'd0, rdy_seen}, 32'd0);
    check("lk_busy_seen", {31'd0, busy_seen}, 32'd0);
    check("lk_locked", {31'd0, key_locked}, 32'd1);
    check("lk_key_p", {28'd0, key_p}, {28'd0, key[3:0]});
    check("lk_key_x", {12'd0, key_x}, {12'd0, key[23:4]});
  endtask

  initial begin
    int          res;
    logic [23:0] k;
    logic [7:0]  c;

    repeat (2) @(negedge clk);
    check_all_zero("por");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

`ifdef C432_KEYLD_CHECKSUM_EN
    do_load(24'hA5C31E, 8'h78, 0, res);
    wait_drain();
    check("t1_busy", {31'd0, busy}, 32'd0);
    apply_reset("t1_rst");

    for (int a = 0; a < 3; a++) begin
      do_load(24'hA5C31E, 8'h79, 0, res);
      wait_drain();
      check("t2_locked", {31'd0, key_locked}, 32'd0);
      check("t2_error", {31'd0, key_error}, {31'd0, a == 2});
      check("t2_ready", {31'd0, sdi_ready}, 32'd0);
    end
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_4th_busy", {31'd0, busy}, 32'd0);
    check("t2_4th_error", {31'd0, key_error}, 32'd1);
    check("t2_4th_keys", {8'd0, key_x, key_p}, 32'd0);
    apply_reset("t2_rst");

    do_load(24'hA5C31E, 8'h78, 1, res);
    wait_drain();
    apply_reset("t3_rst");

    // Two failures, then a mid-load reset: the retry budget must start over.
    for (int a = 0; a < 2; a++) begin
      do_load(24'h123456, 8'h00, 0, res);
      wait_drain();
    end
`else
    do_load(24'h000001, 8'h00, 0, res);
    wait_drain();
    locked_immunity(24'h000001);
    apply_reset("t6_rst");
`endif

    partial_load(10);
    apply_reset("t4_rst");
`ifdef C432_KEYLD_CHECKSUM_EN
    for (int a = 0; a < 2; a++) begin
      do_load(24'h654321, 8'hFF, 0, res);
      wait_drain();
      check("t4_not_error", {31'd0, key_error}, 32'd0);
    end
`endif
    k = 24'($urandom);
    do_load(k, fold(k), 0, res);
    wait_drain();
    locked_immunity(k);
    apply_reset("t5_rst");

    for (int it = 0; it < 10; it++) begin
      k = 24'($urandom);
      c = ($urandom_range(0, 1) == 1) ? fold(k) : (fold(k) ^ 8'($urandom_range(1, 255)));
      do_load(k, c, 2, res);
      wait_drain();
      if (res != 0) apply_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
